// File: rtl/shuffler_feeder.sv
// -----------------------------------------------------------------------------
// shuffler_feeder
//
// Transmit-side front end for the brick shuffler. Bricks arrive one per
// handshake, are assembled into an IN_BRICKS-wide batch in a staging buffer,
// and the finished batch is launched (together with a select word) onto the
// shuffler's registered data/select inputs. A small shift register follows
// the shuffler's fixed latency so o_out_valid/o_out_tag/o_out_count line up
// with the cycle in which the shuffler output carries the batch.
//
// Handshake: a brick transfers on every rising clk edge where
// i_in_valid && o_in_ready are both high; i_in_brick must be stable while
// i_in_valid is high. o_in_ready is high whenever rst_n is high (the staging
// buffer and o_sh_data form a double buffer, so the path never stalls).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_in_valid        producer offers i_in_brick
//   o_in_ready        block can accept a brick
//   i_in_brick        brick data (BL bits)
//   i_in_flush        launch the current partial batch
//   i_sel_we          write the select shadow register
//   i_sel_wdata       new select word; field i selects source of output i
//   o_sh_data         shuffler data input, slot i at [i*BL +: BL]
//   o_sh_sel          shuffler select input
//   o_out_valid       shuffler output holds a launched batch this cycle
//   o_out_tag         batch sequence number aligned with o_out_valid
//   o_out_count       real bricks in that batch (1..IN_BRICKS)
//   o_dbg_state       fill FSM state (0 = EMPTY, 1 = FILLING)
//   o_dbg_fill_cnt    number of bricks currently staged
// -----------------------------------------------------------------------------
module shuffler_feeder #(
  parameter int BL         = 256,
  parameter int IN_BRICKS  = 16,
  parameter int OUT_BRICKS = 16,
  parameter int SEL_BITS   = 4,
  parameter int SHUF_LAT   = 2,
  parameter int CNT_W      = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  input  logic [BL-1:0]                  i_in_brick,
  input  logic                           i_in_flush,
  input  logic                           i_sel_we,
  input  logic [SEL_BITS*OUT_BRICKS-1:0] i_sel_wdata,
  output logic [IN_BRICKS*BL-1:0]        o_sh_data,
  output logic [SEL_BITS*OUT_BRICKS-1:0] o_sh_sel,
  output logic                           o_out_valid,
  output logic [7:0]                     o_out_tag,
  output logic [CNT_W-1:0]               o_out_count,
  output logic                           o_dbg_state,
  output logic [CNT_W-1:0]               o_dbg_fill_cnt
);

  localparam int SW = SEL_BITS * OUT_BRICKS;

  // Identity map: output i takes input i.
  function automatic logic [SW-1:0] identity_sel();
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < OUT_BRICKS; i++) begin
      s[i*SEL_BITS +: SEL_BITS] = SEL_BITS'(i);
    end
    return s;
  endfunction

  localparam logic [SW-1:0] SEL_IDENTITY = identity_sel();

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_FILLING = 1'b1
  } state_t;

  state_t                          r_state;
  logic [CNT_W-1:0]                r_fill_cnt;
  logic [IN_BRICKS-1:0][BL-1:0]    r_stage;
  logic [IN_BRICKS-1:0][BL-1:0]    r_sh_data;
  logic [SW-1:0]                   r_sh_sel;
  logic [SW-1:0]                   r_sel_shadow;
  logic [7:0]                      r_tag_cnt;
  // Stage 0 sits alongside the sh_* registers; stages 1..SHUF_LAT model the
  // shuffler pipeline, so the tail lines up with the shuffler output.
  logic [SHUF_LAT:0]               r_vld_pipe;
  logic [SHUF_LAT:0][7:0]          r_tag_pipe;
  logic [SHUF_LAT:0][CNT_W-1:0]    r_cnt_pipe;

  logic                            w_accept;
  logic                            w_last;
  logic                            w_launch;
  logic [CNT_W-1:0]                w_count;
  logic [SW-1:0]                   w_sel_launch;
  logic [IN_BRICKS-1:0][BL-1:0]    w_merged;

  assign o_in_ready   = rst_n;
  assign w_accept     = i_in_valid && o_in_ready;
  assign w_last       = w_accept && (r_fill_cnt == CNT_W'(IN_BRICKS - 1));
  // A flush only launches if something is (or is about to be) staged.
  assign w_launch     = w_last || (i_in_flush && ((r_fill_cnt != '0) || w_accept));
  assign w_count      = r_fill_cnt + CNT_W'(w_accept);
  // Same-cycle select write bypasses the shadow for this launch.
  assign w_sel_launch = i_sel_we ? i_sel_wdata : r_sel_shadow;

  // Staging contents with the current-cycle brick merged in. Slots past the
  // fill point are already zero because staging is cleared at every launch.
  always_comb begin
    w_merged = r_stage;
    if (w_accept) begin
      for (int i = 0; i < IN_BRICKS; i++) begin
        if (r_fill_cnt == CNT_W'(i)) begin
          w_merged[i] = i_in_brick;
        end
      end
    end
  end

  // Fill FSM: tracks staging occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_fill_cnt <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          // Accept plus flush (or IN_BRICKS == 1) launches immediately.
          if (w_launch) begin
            r_state    <= ST_EMPTY;
            r_fill_cnt <= '0;
          end else if (w_accept) begin
            r_state    <= ST_FILLING;
            r_fill_cnt <= w_count;
          end
        end
        ST_FILLING: begin
          if (w_launch) begin
            r_state    <= ST_EMPTY;
            r_fill_cnt <= '0;
          end else if (w_accept) begin
            r_fill_cnt <= w_count;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_fill_cnt <= '0;
        end
      endcase
    end
  end

  // Datapath: staging, launch registers, select shadow, latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage      <= '0;
      r_sh_data    <= '0;
      r_sh_sel     <= SEL_IDENTITY;
      r_sel_shadow <= SEL_IDENTITY;
      r_tag_cnt    <= '0;
      r_vld_pipe   <= '0;
      r_tag_pipe   <= '0;
      r_cnt_pipe   <= '0;
    end else begin
      r_stage <= w_launch ? '0 : w_merged;
      if (i_sel_we) begin
        r_sel_shadow <= i_sel_wdata;
      end
      if (w_launch) begin
        r_sh_data <= w_merged;
        r_sh_sel  <= w_sel_launch;
        r_tag_cnt <= r_tag_cnt + 8'd1;
      end
      r_vld_pipe    <= {r_vld_pipe[SHUF_LAT-1:0], w_launch};
      r_tag_pipe[0] <= w_launch ? r_tag_cnt : 8'd0;
      r_cnt_pipe[0] <= w_launch ? w_count : '0;
      for (int k = 1; k <= SHUF_LAT; k++) begin
        r_tag_pipe[k] <= r_tag_pipe[k-1];
        r_cnt_pipe[k] <= r_cnt_pipe[k-1];
      end
    end
  end

  assign o_sh_data      = r_sh_data;
  assign o_sh_sel       = r_sh_sel;
  assign o_out_valid    = r_vld_pipe[SHUF_LAT];
  assign o_out_tag      = r_tag_pipe[SHUF_LAT];
  assign o_out_count    = r_cnt_pipe[SHUF_LAT];
  assign o_dbg_state    = r_state;
  assign o_dbg_fill_cnt = r_fill_cnt;

endmodule

// File: tb/tb_shuffler_feeder.sv
// -----------------------------------------------------------------------------
// tb_shuffler_feeder
//
// Directed bench for shuffler_feeder: a table of per-cycle vectors covering
// full fills, flushes and back-to-back launches, followed by hand-written
// sequences for select bypass, slot zeroing, long streaming with tag wrap,
// and mid-operation resets.
// -----------------------------------------------------------------------------
module tb_shuffler_feeder;

  localparam int BL         = 256;
  localparam int IN_BRICKS  = 16;
  localparam int OUT_BRICKS = 16;
  localparam int SEL_BITS   = 4;
  localparam int SHUF_LAT   = 2;
  localparam int CNT_W      = 5;
  localparam int SW         = SEL_BITS * OUT_BRICKS;

  localparam logic [SW-1:0] SEL_ID  = 64'hFEDCBA9876543210;
  localparam logic [SW-1:0] SEL_REV = 64'h0123456789ABCDEF;
  localparam logic [SW-1:0] SEL_ROT = 64'h0FEDCBA987654321;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    in_valid;
  logic                    in_ready;
  logic [BL-1:0]           in_brick;
  logic                    in_flush;
  logic                    sel_we;
  logic [SW-1:0]           sel_wdata;
  logic [IN_BRICKS*BL-1:0] sh_data;
  logic [SW-1:0]           sh_sel;
  logic                    out_valid;
  logic [7:0]              out_tag;
  logic [CNT_W-1:0]        out_count;
  logic                    dbg_state;
  logic [CNT_W-1:0]        dbg_fill_cnt;

  shuffler_feeder #(
    .BL(BL), .IN_BRICKS(IN_BRICKS), .OUT_BRICKS(OUT_BRICKS),
    .SEL_BITS(SEL_BITS), .SHUF_LAT(SHUF_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_brick     (in_brick),
    .i_in_flush     (in_flush),
    .i_sel_we       (sel_we),
    .i_sel_wdata    (sel_wdata),
    .o_sh_data      (sh_data),
    .o_sh_sel       (sh_sel),
    .o_out_valid    (out_valid),
    .o_out_tag      (out_tag),
    .o_out_count    (out_count),
    .o_dbg_state    (dbg_state),
    .o_dbg_fill_cnt (dbg_fill_cnt)
  );

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [BL-1:0] act, input logic [BL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Shuffler model: output i = input slot selected by field i.
  function automatic logic [BL-1:0] shuf(input int i);
    int idx;
    idx = int'(sh_sel[i*SEL_BITS +: SEL_BITS]);
    return sh_data[idx*BL +: BL];
  endfunction

  function automatic logic [BL-1:0] slot(input int i);
    return sh_data[i*BL +: BL];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [BL-1:0] b, input logic fl,
                       input logic we, input logic [SW-1:0] wd);
    in_valid  = v;
    in_brick  = b;
    in_flush  = fl;
    sel_we    = we;
    sel_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic brick(input logic [BL-1:0] b);
    drive(1'b1, b, 1'b0, 1'b0, '0);
    step();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    chk("in_ready_in_reset", in_ready, 1'b0);
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_tag", out_tag, 8'd0);
    chk("rst_out_count", out_count, 5'd0);
    chk("rst_sh_data", sh_data[BL-1:0] | sh_data[IN_BRICKS*BL-1 -: BL], '0);
    chk("rst_sh_sel", sh_sel, SEL_ID);
    chk("rst_fill", dbg_fill_cnt, 5'd0);
  endtask

  // One-cycle asynchronous reset pulse starting just after an edge.
  task automatic pulse_reset();
    idle();
    rst_n = 1'b0;
    step();
    chk("in_ready_pulse", in_ready, 1'b0);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       fl;
    logic       ov;
    logic [7:0] tag;
    logic [4:0] cnt;
    logic [4:0] fill;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [7:0] b, input logic fl, input logic ov,
                     input logic [7:0] tag, input logic [4:0] cnt, input logic [4:0] fill);
    vec_t e;
    e.v = v; e.b = b; e.fl = fl; e.ov = ov; e.tag = tag; e.cnt = cnt; e.fill = fill;
    vq.push_back(e);
  endtask

  initial begin
    int c;
    int launches;
    idle();

    // Table: v, brick, flush | out_valid, tag, count, fill after the edge.
    for (int i = 0; i < 16; i++) add(1, 8'(i), 0, 0, 0, 0, 5'((i + 1) % 16));
    add(0, 0, 0, 0, 0, 0, 0);               // E0+1
    add(0, 0, 0, 1, 0, 16, 0);              // full batch appears
    for (int i = 0; i < 5; i++) add(1, 8'(8'h20 + i), 0, 0, 0, 0, 5'(i + 1));
    add(0, 0, 1, 0, 0, 0, 0);               // flush of 5
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 5, 0);
    add(0, 0, 1, 0, 0, 0, 0);               // flush while empty: ignored
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 8'h30, 0, 0, 0, 0, 1);
    add(1, 8'h31, 1, 0, 0, 0, 0);           // flush with same-cycle brick
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2, 2, 0);
    add(1, 8'h40, 1, 0, 0, 0, 0);           // back-to-back single-brick launches
    add(1, 8'h41, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 3, 1, 0);
    add(0, 0, 0, 1, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0);

    do_reset();
    foreach (vq[i]) begin
      drive(vq[i].v, BL'(vq[i].b), vq[i].fl, 1'b0, '0);
      step();
      chk($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
      chk($sformatf("v%0d_out_valid", i), out_valid, vq[i].ov);
      chk($sformatf("v%0d_fill", i), dbg_fill_cnt, vq[i].fill);
      if (vq[i].ov) begin
        chk($sformatf("v%0d_tag", i), out_tag, vq[i].tag);
        chk($sformatf("v%0d_count", i), out_count, vq[i].cnt);
      end
    end

    // ---- identity batch, then reversed map written mid-fill ----
    do_reset();
    for (int i = 0; i < 16; i++) brick(BL'(i));
    chk("id_sh_sel", sh_sel, SEL_ID);
    for (int i = 0; i < 16; i++) chk($sformatf("id_out%0d", i), shuf(i), BL'(i));
    for (int i = 0; i < 16; i++) begin
      if (i == 3) drive(1'b1, BL'(i), 1'b0, 1'b1, SEL_REV);
      else        drive(1'b1, BL'(i), 1'b0, 1'b0, '0);
      step();
      if (i == 3) begin
        chk("rev_state_filling", dbg_state, 1'b1);
        chk("rev_hold_sel", sh_sel, SEL_ID);
        chk("rev_hold_out0", shuf(0), BL'(0));
      end
    end
    chk("rev_sh_sel", sh_sel, SEL_REV);
    chk("rev_out0", shuf(0), BL'(15));
    chk("rev_out15", shuf(15), BL'(0));
    idle();

    // ---- partial batch of 5 flushed, unfilled slots zero ----
    for (int i = 0; i < 5; i++) brick(BL'(i + 1));
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    step();
    for (int i = 0; i < 16; i++)
      chk($sformatf("flush_slot%0d", i), slot(i), (i < 5) ? BL'(i + 1) : '0);
    chk("flush_sel_shadow", sh_sel, SEL_REV);
    idle();
    step();
    chk("flush_ov_early", out_valid, 1'b0);
    step();
    chk("flush_ov", out_valid, 1'b1);
    chk("flush_count", out_count, 5'd5);
    drive(1'b0, '0, 1'b1, 1'b0, '0);         // flush while empty
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("empty_flush_ov", out_valid, 1'b0);
    end
    chk("empty_flush_data", slot(0), BL'(1));

    // ---- select bypass on last-slot acceptance ----
    for (int i = 0; i < 15; i++) brick(BL'(8'h50 + i));
    drive(1'b1, BL'(8'h5F), 1'b0, 1'b1, SEL_ROT);
    step();
    chk("bypass_sel", sh_sel, SEL_ROT);
    chk("bypass_out0", shuf(0), BL'(8'h51));
    chk("bypass_out15", shuf(15), BL'(8'h50));
    for (int i = 0; i < 16; i++) brick(BL'(8'h60 + i));
    chk("shadow_sel", sh_sel, SEL_ROT);
    chk("shadow_out0", shuf(0), BL'(8'h61));
    idle();

    // ---- streaming: 258 batches, tags wrap 255 -> 0 ----
    do_reset();
    launches = 0;
    for (c = 0; c < 258 * 16 + 3; c++) begin
      if (c < 258 * 16) drive(1'b1, BL'(c), 1'b0, 1'b0, '0);
      else              idle();
      if (c < 258 * 16 && (c % 16) == 15) begin
        exp_q.push_back(8'(launches));
        launches++;
      end
      step();
      chk("stream_in_ready", in_ready, 1'b1);
      chk($sformatf("stream_ov_c%0d", c), out_valid,
          (c >= 17 && ((c - 17) % 16) == 0) ? 1'b1 : 1'b0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_batch", 1'b1, 1'b0);
        end else begin
          chk($sformatf("stream_tag_c%0d", c), out_tag, exp_q.pop_front());
          chk("stream_count", out_count, 5'd16);
        end
      end
    end
    chk("stream_all_seen", exp_q.size(), 0);

    // ---- reset mid-fill and reset with a batch in flight ----
    do_reset();
    for (int i = 0; i < 10; i++) brick(BL'(8'h70 + i));
    chk("pre_rst_fill", dbg_fill_cnt, 5'd10);
    pulse_reset();
    chk("mid_rst_fill", dbg_fill_cnt, 5'd0);
    chk("mid_rst_state", dbg_state, 1'b0);
    chk("mid_rst_sel", sh_sel, SEL_ID);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_ov", out_valid, 1'b0);
    end
    for (int i = 0; i < 16; i++) brick(BL'(8'h80 + i));
    chk("flight_launch_data", slot(0), BL'(8'h80));
    pulse_reset();
    chk("flight_rst_sel", sh_sel, SEL_ID);
    chk("flight_rst_data", slot(0), '0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flight_rst_ov", out_valid, 1'b0);
    end
    drive(1'b1, BL'(8'h77), 1'b1, 1'b0, '0);
    step();
    idle();
    step();
    chk("fresh_ov_early", out_valid, 1'b0);
    step();
    chk("fresh_ov", out_valid, 1'b1);
    chk("fresh_tag", out_tag, 8'd0);
    chk("fresh_count", out_count, 5'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
